// File: rtl/ex_forward_track_unit_pkg.sv
// Shared widths, HI/LO op encodings and tracker entry layout
// for the EX-stage forwarding and hazard unit.
package ex_forward_track_unit_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [1:0] {
        HILO_NONE  = 2'b00,
        HILO_RD_HI = 2'b01,
        HILO_RD_LO = 2'b10,
        HILO_WR    = 2'b11
    } hilo_op_e;

    typedef struct packed {
        logic            vld;
        logic [RA_W-1:0] dst;
        logic            is_ld;
        logic [XLEN-1:0] data;
    } fwd_ent_t;

    localparam int ENT_W = $bits(fwd_ent_t);

    // Register 0 is hard-wired, so it never matches a writer.
    function automatic logic ent_match(
        input fwd_ent_t        e,
        input logic [RA_W-1:0] r
    );
        return e.vld && (e.dst == r) && (r != '0);
    endfunction

endpackage

// File: rtl/ex_forward_track_unit_if.sv
// EX-side bundle between the ID/EX register, the
// forwarding unit and the ALU operand muxes.
interface ex_forward_track_unit_if;
    import ex_forward_track_unit_pkg::*;

    logic            advance;
    logic            flush;
    logic            ex_valid;
    logic [RA_W-1:0] ex_rs;
    logic [RA_W-1:0] ex_rt;
    logic            ex_use_rt;
    logic [XLEN-1:0] ex_in1;
    logic [XLEN-1:0] ex_in2;
    logic [1:0]      ex_hilo_op;
    logic            ex_wr_en;
    logic [RA_W-1:0] ex_dst;
    logic            ex_is_load;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] ex_hi;
    logic [XLEN-1:0] ex_lo;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            stall;

    modport master (
        output advance, flush, ex_valid,
        output ex_rs, ex_rt, ex_use_rt,
        output ex_in1, ex_in2, ex_hilo_op,
        output ex_wr_en, ex_dst, ex_is_load,
        output ex_result, ex_hi, ex_lo,
        output mem_rdata,
        input  in1, in2, hi_q, lo_q, stall
    );

    modport slave (
        input  advance, flush, ex_valid,
        input  ex_rs, ex_rt, ex_use_rt,
        input  ex_in1, ex_in2, ex_hilo_op,
        input  ex_wr_en, ex_dst, ex_is_load,
        input  ex_result, ex_hi, ex_lo,
        input  mem_rdata,
        output in1, in2, hi_q, lo_q, stall
    );

endinterface

// File: rtl/ex_forward_track_unit_fwd_track_entry.sv
// One tracker stage: records an older writer and swaps
// in load data as the load leaves MEM.
module fwd_track_entry
    import ex_forward_track_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_en,
    input  fwd_ent_t        i_d,
    input  logic            i_patch,
    input  logic [XLEN-1:0] i_patch_data,
    output fwd_ent_t        o_q
);

    fwd_ent_t r_q;

    // Flush only kills validity; payload is don't-care afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q.vld <= 1'b0;
        end else if (i_en) begin
            r_q.vld   <= i_d.vld;
            r_q.dst   <= i_d.dst;
            r_q.is_ld <= i_d.is_ld & ~i_patch;
            r_q.data  <= i_patch ? i_patch_data : i_d.data;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ex_forward_track_unit.sv
// EX-stage forwarding: youngest-match operand select,
// one-bubble load-use stall and the HI/LO pair.
module ex_forward_track_unit
    import ex_forward_track_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic                   clk,
    input logic                   rst,
    ex_forward_track_unit_if.slave bus
);

    fwd_ent_t        w_ent   [DEPTH];
    fwd_ent_t        w_din   [DEPTH];
    logic            w_patch [DEPTH];
    logic            w_shift;
    logic            w_stall;
    logic [XLEN-1:0] w_in1;
    logic [XLEN-1:0] w_in2;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    assign w_shift = bus.advance & ~bus.flush;

    // Only entry 0 can hold a load whose data is not back yet.
    assign w_stall = bus.ex_valid & w_ent[0].is_ld &
        (ent_match(w_ent[0], bus.ex_rs) |
         (bus.ex_use_rt & ent_match(w_ent[0], bus.ex_rt)));

    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        if (k == 0) begin : g_head
            assign w_din[k] = {
                bus.ex_valid & bus.ex_wr_en & ~w_stall,
                bus.ex_dst,
                bus.ex_is_load,
                bus.ex_result
            };
            assign w_patch[k] = 1'b0;
        end else if (k == 1) begin : g_wb
            assign w_din[k]   = w_ent[k-1];
            assign w_patch[k] = w_ent[0].is_ld;
        end else begin : g_tail
            assign w_din[k]   = w_ent[k-1];
            assign w_patch[k] = 1'b0;
        end

        fwd_track_entry u_ent (
            .clk          (clk),
            .rst          (rst),
            .i_clr        (bus.flush),
            .i_en         (w_shift),
            .i_d          (w_din[k]),
            .i_patch      (w_patch[k]),
            .i_patch_data (bus.mem_rdata),
            .o_q          (w_ent[k])
        );
    end

    // Oldest first so the youngest match is the last to win.
    always_comb begin
        w_in1 = bus.ex_in1;
        w_in2 = bus.ex_in2;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_match(w_ent[k], bus.ex_rs))
                w_in1 = w_ent[k].data;
            if (bus.ex_use_rt && ent_match(w_ent[k], bus.ex_rt))
                w_in2 = w_ent[k].data;
        end
        case (bus.ex_hilo_op)
            HILO_RD_HI: w_in1 = r_hi;
            HILO_RD_LO: w_in1 = r_lo;
            default:    ;
        endcase
    end

    // HI/LO commit only when the writer actually leaves EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_shift && !w_stall && bus.ex_valid &&
                     bus.ex_hilo_op == HILO_WR) begin
            r_hi <= bus.ex_hi;
            r_lo <= bus.ex_lo;
        end
    end

    assign bus.in1   = w_in1;
    assign bus.in2   = w_in2;
    assign bus.hi_q  = r_hi;
    assign bus.lo_q  = r_lo;
    assign bus.stall = w_stall;

endmodule

// File: tb/tb_ex_forward_track_unit.sv
// Bench for ex_forward_track_unit: DEPTH=2 and DEPTH=4
// builds driven in lockstep against a history-list model.
module tb_ex_forward_track_unit;

    typedef struct {
        logic        vld;
        logic [4:0]  dst;
        logic        ld;
        logic [31:0] data;
    } m_t;

    logic        clk = 1'b0;
    logic        rst, advance, flush, ex_valid;
    logic        ex_use_rt, ex_wr_en, ex_is_load;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [1:0]  ex_hilo_op;
    logic [31:0] ex_in1, ex_in2, ex_result;
    logic [31:0] ex_hi, ex_lo, mem_rdata;

    logic [31:0] o_in1 [2];
    logic [31:0] o_in2 [2];
    logic [31:0] o_hi  [2];
    logic [31:0] o_lo  [2];
    logic        o_stall [2];

    int checks   = 0;
    int failures = 0;

    m_t          hist [2][8];
    logic [31:0] mhi [2];
    logic [31:0] mlo [2];
    int          dep [2] = '{2, 4};

    always #5 clk = ~clk;

    ex_forward_track_unit_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus[g].advance    = advance;
        assign bus[g].flush      = flush;
        assign bus[g].ex_valid   = ex_valid;
        assign bus[g].ex_rs      = ex_rs;
        assign bus[g].ex_rt      = ex_rt;
        assign bus[g].ex_use_rt  = ex_use_rt;
        assign bus[g].ex_in1     = ex_in1;
        assign bus[g].ex_in2     = ex_in2;
        assign bus[g].ex_hilo_op = ex_hilo_op;
        assign bus[g].ex_wr_en   = ex_wr_en;
        assign bus[g].ex_dst     = ex_dst;
        assign bus[g].ex_is_load = ex_is_load;
        assign bus[g].ex_result  = ex_result;
        assign bus[g].ex_hi      = ex_hi;
        assign bus[g].ex_lo      = ex_lo;
        assign bus[g].mem_rdata  = mem_rdata;
        assign o_in1[g]   = bus[g].in1;
        assign o_in2[g]   = bus[g].in2;
        assign o_hi[g]    = bus[g].hi_q;
        assign o_lo[g]    = bus[g].lo_q;
        assign o_stall[g] = bus[g].stall;

        ex_forward_track_unit #(.DEPTH(g == 0 ? 2 : 4)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );
    end

    task automatic chk(input string tag, input int d,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d got=%h want=%h", tag, d, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input int d,
                                        input logic [4:0] r,
                                        input logic [31:0] dflt);
        if (r == 0) return dflt;
        for (int i = 0; i < dep[d]; i++)
            if (hist[d][i].vld && hist[d][i].dst == r)
                return hist[d][i].data;
        return dflt;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++)
                hist[d][i] = '{1'b0, 5'd0, 1'b0, 32'd0};
            mhi[d] = 0;
            mlo[d] = 0;
        end
    endtask

    // Check current outputs vs model, then clock and age history.
    task automatic tick(input string tag);
        logic        st [2];
        logic [31:0] e1, e2;
        #1;
        for (int d = 0; d < 2; d++) begin
            st[d] = ex_valid && hist[d][0].vld && hist[d][0].ld &&
                ((ex_rs != 0 && hist[d][0].dst == ex_rs) ||
                 (ex_use_rt && ex_rt != 0 && hist[d][0].dst == ex_rt));
            if (ex_hilo_op == 2'b01)      e1 = mhi[d];
            else if (ex_hilo_op == 2'b10) e1 = mlo[d];
            else                          e1 = fwd(d, ex_rs, ex_in1);
            e2 = ex_use_rt ? fwd(d, ex_rt, ex_in2) : ex_in2;
            chk({tag, ".stall"}, d, 32'(o_stall[d]), 32'(st[d]));
            chk({tag, ".in1"}, d, o_in1[d], e1);
            chk({tag, ".in2"}, d, o_in2[d], e2);
            chk({tag, ".hi"}, d, o_hi[d], mhi[d]);
            chk({tag, ".lo"}, d, o_lo[d], mlo[d]);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (flush) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 8; i++) hist[d][i].vld = 1'b0;
        end else if (advance) begin
            for (int d = 0; d < 2; d++) begin
                if (ex_valid && ex_hilo_op == 2'b11 && !st[d]) begin
                    mhi[d] = ex_hi;
                    mlo[d] = ex_lo;
                end
                if (hist[d][0].ld) begin
                    hist[d][0].ld   = 1'b0;
                    hist[d][0].data = mem_rdata;
                end
                for (int i = dep[d] - 1; i >= 1; i--)
                    hist[d][i] = hist[d][i-1];
                hist[d][0] = '{ex_valid && ex_wr_en && !st[d],
                               ex_dst, ex_is_load, ex_result};
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; advance = 1; flush = 0; ex_valid = 0;
        ex_use_rt = 0; ex_wr_en = 0; ex_is_load = 0;
        ex_rs = 0; ex_rt = 0; ex_dst = 0; ex_hilo_op = 0;
        ex_in1 = $urandom; ex_in2 = $urandom;
        ex_result = $urandom; ex_hi = $urandom;
        ex_lo = $urandom; mem_rdata = $urandom;
    endtask

    task automatic alu(input logic [4:0] d, input logic [31:0] v);
        idle();
        ex_valid = 1; ex_wr_en = 1; ex_dst = d; ex_result = v;
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        tick("rst0");
        chk("rst_stall", 0, 32'(o_stall[0]), 32'd0);
        chk("rst_hi", 1, o_hi[1], 32'd0);
        idle(); rst = 1; ex_valid = 1; ex_use_rt = 1;
        ex_rs = 5'd4; ex_rt = 5'd9;
        #1;
        chk("rst_in1", 0, o_in1[0], ex_in1);
        chk("rst_in2", 1, o_in2[1], ex_in2);
        tick("rst1");

        alu(5'd3, 32'h11); tick("b2b_a");
        alu(5'd3, 32'h22); tick("b2b_b");
        idle(); ex_valid = 1; ex_rs = 5'd3; ex_in1 = 32'h1234;
        #1;
        chk("b2b_young", 0, o_in1[0], 32'h22);
        tick("b2b_c");
        idle(); ex_valid = 1; ex_rs = 5'd0; ex_in1 = 32'h4321;
        #1;
        chk("b2b_r0", 0, o_in1[0], 32'h4321);
        tick("b2b_d");

        alu(5'd5, 32'h100); ex_is_load = 1; tick("lu_lw");
        idle(); ex_valid = 1; ex_use_rt = 1; ex_rt = 5'd5;
        ex_in2 = 32'h777; ex_wr_en = 1; ex_dst = 5'd6;
        advance = 0;
        #1;
        chk("lu_stall", 0, 32'(o_stall[0]), 32'd1);
        tick("lu_hold0");
        #1;
        chk("lu_hold", 1, 32'(o_stall[1]), 32'd1);
        advance = 1; mem_rdata = 32'hDEADBEEF;
        tick("lu_go");
        mem_rdata = $urandom;
        #1;
        chk("lu_clear", 0, 32'(o_stall[0]), 32'd0);
        chk("lu_data", 0, o_in2[0], 32'hDEADBEEF);
        tick("lu_use");

        idle(); ex_valid = 1; ex_hilo_op = 2'b11;
        ex_hi = 32'hA; ex_lo = 32'hB;
        tick("hl_wr");
        idle(); ex_valid = 1; ex_hilo_op = 2'b10;
        #1;
        chk("hl_rdlo", 0, o_in1[0], 32'hB);
        tick("hl_lo");
        idle(); ex_valid = 1; ex_hilo_op = 2'b01;
        #1;
        chk("hl_rdhi", 1, o_in1[1], 32'hA);
        tick("hl_hi");
        alu(5'd8, 32'h200); ex_is_load = 1; tick("hl_lw");
        idle(); ex_valid = 1; ex_hilo_op = 2'b11; ex_rs = 5'd8;
        ex_hi = 32'hC; ex_lo = 32'hD;
        tick("hl_stallwr");
        idle(); ex_valid = 1; ex_hilo_op = 2'b01;
        #1;
        chk("hl_kept", 0, o_hi[0], 32'hA);
        tick("hl_after");

        alu(5'd7, 32'h55); tick("fl_alu");
        idle(); flush = 1; tick("fl_flush");
        idle(); ex_valid = 1; ex_rs = 5'd7; ex_in1 = 32'hABC;
        #1;
        chk("fl_in1", 0, o_in1[0], 32'hABC);
        chk("fl_stall", 1, 32'(o_stall[1]), 32'd0);
        tick("fl_use");

        alu(5'd9, 32'h99); tick("d4_wr");
        idle(); tick("d4_i1");
        idle(); tick("d4_i2");
        idle(); ex_valid = 1; ex_rs = 5'd9; ex_in1 = 32'h5A5A;
        #1;
        chk("d4_hit", 1, o_in1[1], 32'h99);
        chk("d4_drop2", 0, o_in1[0], 32'h5A5A);
        tick("d4_c3");
        idle(); tick("d4_i4");
        idle(); ex_valid = 1; ex_rs = 5'd9; ex_in1 = 32'h6B6B;
        #1;
        chk("d4_drop4", 1, o_in1[1], 32'h6B6B);
        tick("d4_c5");

        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            advance    = ($urandom_range(0, 9) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            ex_valid   = ($urandom_range(0, 4) != 0);
            ex_use_rt  = 1'($urandom_range(0, 1));
            ex_wr_en   = ($urandom_range(0, 3) != 0);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rs      = 5'($urandom_range(0, 7));
            ex_rt      = 5'($urandom_range(0, 7));
            ex_dst     = 5'($urandom_range(0, 7));
            ex_hilo_op = 2'($urandom_range(0, 3));
            ex_in1     = $urandom;
            ex_in2     = $urandom;
            ex_result  = $urandom;
            ex_hi      = $urandom;
            ex_lo      = $urandom;
            mem_rdata  = $urandom;
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
